// File: rtl/dm_pkg.sv
// Debug-module shared types: arbiter FSM state and the debug snapshot the
// bus arbiter exposes so checkers can observe its internal state.
package dm;

  // Width of the index fields in the debug snapshot (covers up to 8 requesters).
  localparam int unsigned ArbIdxW = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Snapshot of the arbiter FSM: current state, round-robin pointer, latched winner.
  typedef struct packed {
    arb_state_e           state;
    logic [ArbIdxW-1:0]   ptr;
    logic [ArbIdxW-1:0]   win;
  } arb_dbg_t;

endpackage

// File: rtl/dm_rr_arb.sv
// Combinational round-robin winner selection. The search starts at ptr+1
// (mod NrReq) and wraps, so the requester granted last has lowest priority.
module dm_rr_arb #(
  parameter int unsigned NrReq = 2,
  parameter int unsigned IdxW  = $clog2(NrReq)
) (
  input  logic [NrReq-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [IdxW-1:0]  idx,
  output logic             any
);

  logic [IdxW-1:0] cand;

  // Walk the requesters starting after ptr; the first active one wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= NrReq; i++) begin
      cand = IdxW'((32'(ptr) + i) % NrReq);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing one master bus port between NrReq requesters.
// Optional response timeout: define DM_BUS_ARB_TIMEOUT_EN.
//
// Handshake: a requester holds req_i (with address/data/we/be stable) until it
// sees gnt_o; the grant is the cycle where master_req_o and master_gnt_i are both
// high. The response arrives later as a single-cycle master_r_valid_i (never in
// the grant cycle) and is forwarded combinationally as r_valid_o[win].
// Dropping req_i before the grant withdraws the request.
module dm_bus_arbiter
  import dm::*;
#(
  parameter int unsigned NrReq         = 2,
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NrReq-1:0]                   req_i,
  input  logic [NrReq-1:0][BusWidth-1:0]     add_i,
  input  logic [NrReq-1:0]                   we_i,
  input  logic [NrReq-1:0][BusWidth-1:0]     wdata_i,
  input  logic [NrReq-1:0][BusWidth/8-1:0]   be_i,
  output logic [NrReq-1:0]                   gnt_o,
  output logic [NrReq-1:0]                   r_valid_o,
  output logic [BusWidth-1:0]                r_rdata_o,
  output logic [NrReq-1:0]                   r_err_o,
  output logic                               master_req_o,
  output logic [BusWidth-1:0]                master_add_o,
  output logic                               master_we_o,
  output logic [BusWidth-1:0]                master_wdata_o,
  output logic [BusWidth/8-1:0]              master_be_o,
  input  logic                               master_gnt_i,
  input  logic                               master_r_valid_i,
  input  logic [BusWidth-1:0]                master_r_rdata_i,
  output arb_dbg_t                           dbg
);

  localparam int unsigned IdxW = $clog2(NrReq);

  arb_state_e      state, state_next;
  logic [IdxW-1:0] ptr, win;
  logic [IdxW-1:0] arb_idx;
  logic            arb_any;

  dm_rr_arb #(
    .NrReq (NrReq),
    .IdxW  (IdxW)
  ) u_rr_arb (
    .req (req_i),
    .ptr (ptr),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef DM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt;
  logic            timeout_hit;

  // Fires on the TimeoutCycles-th RESP cycle (count includes the current cycle).
  assign timeout_hit = (state == ARB_RESP) && (cnt == CntW'(TimeoutCycles - 1));

  // Count RESP cycles; cleared when the grant moves us into RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (state != ARB_RESP && state_next == ARB_RESP) begin
      cnt <= '0;
    end else if (state == ARB_RESP) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
`endif

  // State register, winner latch and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
      ptr   <= IdxW'(NrReq - 1);
      win   <= '0;
    end else begin
      state <= state_next;
      if (state == ARB_IDLE && arb_any) begin
        win <= arb_idx;
      end
      // Pointer only moves on an actual grant, so an aborted request keeps priority.
      if (state == ARB_REQ && state_next == ARB_RESP) begin
        ptr <= win;
      end
    end
  end

  // Next state and all bus/requester outputs; reset forces every output low.
  always_comb begin
    state_next     = state;
    gnt_o          = '0;
    r_valid_o      = '0;
    r_err_o        = '0;
    r_rdata_o      = master_r_rdata_i;
    master_req_o   = 1'b0;
    master_add_o   = '0;
    master_we_o    = 1'b0;
    master_wdata_o = '0;
    master_be_o    = '0;
    unique case (state)
      ARB_IDLE: begin
        if (arb_any) state_next = ARB_REQ;
      end
      ARB_REQ: begin
        master_req_o   = req_i[win];
        master_add_o   = add_i[win];
        master_we_o    = we_i[win];
        master_wdata_o = wdata_i[win];
        master_be_o    = be_i[win];
        if (!req_i[win]) begin
          state_next = ARB_IDLE;
        end else if (master_gnt_i) begin
          gnt_o[win] = 1'b1;
          state_next = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (master_r_valid_i) begin
          r_valid_o[win] = 1'b1;
          state_next     = ARB_IDLE;
        end
`ifdef DM_BUS_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          r_valid_o[win] = 1'b1;
          r_err_o[win]   = 1'b1;
          r_rdata_o      = '0;
          state_next     = ARB_IDLE;
        end
`endif
      end
      default: state_next = ARB_IDLE;
    endcase
    if (rst_i) begin
      state_next     = ARB_IDLE;
      gnt_o          = '0;
      r_valid_o      = '0;
      r_err_o        = '0;
      master_req_o   = 1'b0;
      master_add_o   = '0;
      master_we_o    = 1'b0;
      master_wdata_o = '0;
      master_be_o    = '0;
    end
  end

  assign dbg = '{state: state, ptr: ArbIdxW'(ptr), win: ArbIdxW'(win)};

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter with a queue-based scoreboard. Build with
// DM_BUS_ARB_TIMEOUT_EN defined to exercise the timeout path (TimeoutCycles=4).
module tb_dm_bus_arbiter;
  import dm::*;

  localparam int unsigned NrReq    = 2;
  localparam int unsigned BusWidth = 32;
`ifdef DM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 4;
`else
  localparam int unsigned TimeoutCycles = 255;
`endif
  localparam int unsigned EW = 80;

  logic                             clk;
  logic                             rst_i;
  logic [NrReq-1:0]                 req_i;
  logic [NrReq-1:0][BusWidth-1:0]   add_i;
  logic [NrReq-1:0]                 we_i;
  logic [NrReq-1:0][BusWidth-1:0]   wdata_i;
  logic [NrReq-1:0][BusWidth/8-1:0] be_i;
  logic [NrReq-1:0]                 gnt_o;
  logic [NrReq-1:0]                 r_valid_o;
  logic [BusWidth-1:0]              r_rdata_o;
  logic [NrReq-1:0]                 r_err_o;
  logic                             master_req_o;
  logic [BusWidth-1:0]              master_add_o;
  logic                             master_we_o;
  logic [BusWidth-1:0]              master_wdata_o;
  logic [BusWidth/8-1:0]            master_be_o;
  logic                             master_gnt_i;
  logic                             master_r_valid_i;
  logic [BusWidth-1:0]              master_r_rdata_i;
  arb_dbg_t                         dbg;

  int checks = 0;
  int errors = 0;
  int req_pulses = 0;
  logic req_d = 1'b0;
  logic [EW-1:0] exp_q[$];

  dm_bus_arbiter #(
    .NrReq         (NrReq),
    .BusWidth      (BusWidth),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .add_i            (add_i),
    .we_i             (we_i),
    .wdata_i          (wdata_i),
    .be_i             (be_i),
    .gnt_o            (gnt_o),
    .r_valid_o        (r_valid_o),
    .r_rdata_o        (r_rdata_o),
    .r_err_o          (r_err_o),
    .master_req_o     (master_req_o),
    .master_add_o     (master_add_o),
    .master_we_o      (master_we_o),
    .master_wdata_o   (master_wdata_o),
    .master_be_o      (master_be_o),
    .master_gnt_i     (master_gnt_i),
    .master_r_valid_i (master_r_valid_i),
    .master_r_rdata_i (master_r_rdata_i),
    .dbg              (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] mk_gnt(input logic [2:0] idx, input logic [31:0] add,
                                           input logic we, input logic [31:0] wdata,
                                           input logic [3:0] be);
    return {7'd0, 1'b0, idx, add, we, wdata, be};
  endfunction

  function automatic logic [EW-1:0] mk_rsp(input logic [2:0] idx, input logic err,
                                           input logic [31:0] data);
    return {1'b1, idx, err, 43'd0, data};
  endfunction

  // Hand-written expected bus request for each requester (matches the drive table).
  function automatic logic [EW-1:0] exp_gnt(input int idx);
    if (idx == 0) return mk_gnt(3'd0, 32'h4000_0000, 1'b0, 32'hC0DE_0000, 4'hF);
    else          return mk_gnt(3'd1, 32'h4000_0100, 1'b1, 32'hC0DE_0001, 4'h3);
  endfunction

  function automatic logic [2:0] oh2idx(input logic [NrReq-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < NrReq; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_master_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (master_req_o) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL master_req_wait actual=0 required=1");
  endtask

  // Grant the pending request, then respond 'delay' cycles after the grant.
  task automatic grant_and_respond(input int delay, input logic [31:0] data,
                                   input logic [NrReq-1:0] req_after);
    bit ok;
    wait_master_req(ok);
    if (!ok) return;
    master_gnt_i = 1'b1;
    tick();
    master_gnt_i = 1'b0;
    req_i = req_after;
    repeat (delay - 1) tick();
    master_r_valid_i = 1'b1;
    master_r_rdata_i = data;
    tick();
    master_r_valid_i = 1'b0;
    master_r_rdata_i = '0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] act;
    if (master_req_o === 1'b1 && req_d === 1'b0) req_pulses++;
    req_d = master_req_o;
    if (|gnt_o) begin
      check("gnt_onehot", EW'($countones(gnt_o)), EW'(1));
      act = mk_gnt(oh2idx(gnt_o), master_add_o, master_we_o, master_wdata_o, master_be_o);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_gnt actual=%h required=none", act);
      end else begin
        check("gnt", act, exp_q.pop_front());
      end
    end
    if (|r_valid_o) begin
      check("rsp_onehot", EW'($countones(r_valid_o)), EW'(1));
      check("err_align", EW'(r_err_o & ~r_valid_o), EW'(0));
      act = mk_rsp(oh2idx(r_valid_o), |r_err_o, r_rdata_o);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%h required=none", act);
      end else begin
        check("rsp", act, exp_q.pop_front());
      end
    end else if (|r_err_o) begin
      checks++;
      errors++;
      $display("FAIL err_without_valid actual=%b required=0", r_err_o);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int p0;
    int bad;
    rst_i            = 1'b1;
    req_i            = '0;
    add_i[0]         = 32'h4000_0000;
    add_i[1]         = 32'h4000_0100;
    we_i             = 2'b10;
    wdata_i[0]       = 32'hC0DE_0000;
    wdata_i[1]       = 32'hC0DE_0001;
    be_i[0]          = 4'hF;
    be_i[1]          = 4'h3;
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b0;
    master_r_rdata_i = '0;

    // Reset state: outputs low and pointer at NrReq-1, with a request already pending.
    do_reset();
    req_i = 2'b01;
    @(negedge clk);
    check("rst_outputs", EW'({gnt_o, r_valid_o, r_err_o, master_req_o, master_add_o,
                              master_we_o, master_wdata_o, master_be_o}), EW'(0));
    check("rst_dbg", EW'(dbg), EW'({ARB_IDLE, 3'd1, 3'd0}));

    // Single requester, response two cycles after the grant.
    do_reset();
    p0 = req_pulses;
    req_i = 2'b01;
    exp_q.push_back(exp_gnt(0));
    exp_q.push_back(mk_rsp(3'd0, 1'b0, 32'hDEAD_BEEF));
    grant_and_respond(2, 32'hDEAD_BEEF, 2'b00);
    repeat (3) tick();
    check("single_req_pulses", EW'(req_pulses - p0), EW'(1));

    // Contention: both held, four back-to-back transactions alternate 0,1,0,1.
    do_reset();
    req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_gnt(i % 2));
      exp_q.push_back(mk_rsp(3'(i % 2), 1'b0, 32'hA000_0000 + 32'(i)));
      grant_and_respond(1, 32'hA000_0000 + 32'(i), 2'b11);
    end
    req_i = 2'b00;
    tick();

    // Abort: move ptr to 0, then requester 1 withdraws before its grant.
    req_i = 2'b01;
    exp_q.push_back(exp_gnt(0));
    exp_q.push_back(mk_rsp(3'd0, 1'b0, 32'h1111_2222));
    grant_and_respond(1, 32'h1111_2222, 2'b00);
    req_i = 2'b10;
    wait_master_req(ok);
    check("abort_win", EW'(dbg.win), EW'(1));
    req_i = 2'b00;
    @(negedge clk);
    check("abort_no_gnt", EW'({master_req_o, gnt_o}), EW'(0));
    tick();
    @(negedge clk);
    check("abort_dbg", EW'(dbg), EW'({ARB_IDLE, 3'd0, 3'd1}));
    tick();
    req_i = 2'b11;
    exp_q.push_back(exp_gnt(1));
    exp_q.push_back(mk_rsp(3'd1, 1'b0, 32'h3333_4444));
    grant_and_respond(1, 32'h3333_4444, 2'b00);

    // Reset while in REQ forces the bus request low.
    req_i = 2'b01;
    wait_master_req(ok);
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_in_req", EW'({master_req_o, gnt_o, master_add_o}), EW'(0));
    tick();
    rst_i = 1'b0;
    // Re-arbitrate (winner 0), grant, then reset in RESP with a response pending.
    tick();
    exp_q.push_back(exp_gnt(0));
    master_gnt_i = 1'b1;
    tick();
    master_gnt_i = 1'b0;
    req_i = 2'b00;
    rst_i = 1'b1;
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    check("rst_resp_valid", EW'(r_valid_o), EW'(0));
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_resp_after", EW'({r_valid_o, dbg.state}), EW'({2'b00, ARB_IDLE}));
    tick();
    master_r_valid_i = 1'b0;

    // Stray response in IDLE is ignored.
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'hBAD0_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_rsp", EW'({r_valid_o, dbg.state}), EW'({2'b00, ARB_IDLE}));
      tick();
    end
    master_r_valid_i = 1'b0;
    master_r_rdata_i = '0;

    // No response after grant: timeout on the 4th RESP cycle, or wait indefinitely.
    req_i = 2'b01;
    exp_q.push_back(exp_gnt(0));
    wait_master_req(ok);
    master_gnt_i = 1'b1;
    tick();
    master_gnt_i = 1'b0;
    req_i = 2'b00;
    master_r_rdata_i = 32'h7777_7777;
`ifdef DM_BUS_ARB_TIMEOUT_EN
    exp_q.push_back(mk_rsp(3'd0, 1'b1, 32'h0000_0000));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("timeout_wait", EW'({r_valid_o, dbg.state}), EW'({2'b00, ARB_RESP}));
      tick();
    end
    @(negedge clk);
    check("timeout_fire", EW'({r_valid_o, r_err_o, r_rdata_o}), EW'({2'b01, 2'b01, 32'h0}));
    tick();
    @(negedge clk);
    check("timeout_idle", EW'(dbg.state), EW'(ARB_IDLE));
`else
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dbg.state !== ARB_RESP || r_valid_o !== 2'b00) bad++;
      tick();
    end
    check("no_timeout_hold", EW'(bad), EW'(0));
    exp_q.push_back(mk_rsp(3'd0, 1'b0, 32'h7777_7777));
    master_r_valid_i = 1'b1;
    tick();
    master_r_valid_i = 1'b0;
`endif
    master_r_rdata_i = '0;

    repeat (3) tick();
    check("queue_empty", EW'(exp_q.size()), EW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
